// File: rtl/fetch_stage.sv
// Instruction fetch: two-word boot PC load, then one word per cycle into IF/ID.
// Latency 1 cycle; stall freezes PC and IF/ID; redirects insert exactly one NOP bubble.
module fetch_stage #(
    parameter logic [15:0] NOP_WORD       = 16'h4000,
    parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic        pc_choose_memory,
    input  logic [31:0] mem_pc,
    input  logic        clear_instruction,
    output logic [15:0] instruction,
    output logic [31:0] pc_out,
    output logic [15:0] immediate,
    output logic        fetch_valid
);

    localparam logic [1:0] BOOT_HI = 2'd0;
    localparam logic [1:0] BOOT_LO = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    localparam logic [31:0] RESET_VEC_LO = RESET_VEC_ADDR + 32'd1;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_inc;

    assign pc_inc = pc + 32'd1;

    always_comb begin
        case (state)
            BOOT_HI: imem_addr = RESET_VEC_ADDR;
            BOOT_LO: imem_addr = RESET_VEC_LO;
            default: imem_addr = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT_HI;
            pc          <= 32'd0;
            instruction <= NOP_WORD;
            pc_out      <= 32'd0;
            immediate   <= 16'd0;
            fetch_valid <= 1'b0;
        end else begin
            case (state)
                BOOT_HI: begin
                    pc[31:16]   <= imem_data;
                    instruction <= NOP_WORD;
                    fetch_valid <= 1'b0;
                    state       <= BOOT_LO;
                end
                BOOT_LO: begin
                    pc[15:0]    <= imem_data;
                    instruction <= NOP_WORD;
                    fetch_valid <= 1'b0;
                    state       <= RUN;
                end
                RUN: begin
                    // Redirects outrank stall so a RET/jump is never lost behind a hazard.
                    if (pc_choose_memory) begin
                        pc          <= mem_pc;
                        instruction <= NOP_WORD;
                        fetch_valid <= 1'b0;
                    end else if (jump_taken) begin
                        pc          <= jump_target;
                        instruction <= NOP_WORD;
                        fetch_valid <= 1'b0;
                    end else if (stall) begin
                        pc          <= pc;
                    end else if (clear_instruction) begin
                        immediate   <= imem_data;
                        instruction <= NOP_WORD;
                        fetch_valid <= 1'b0;
                        pc          <= pc_inc;
                    end else begin
                        instruction <= imem_data;
                        pc_out      <= pc_inc;
                        pc          <= pc_inc;
                        fetch_valid <= 1'b1;
                    end
                end
                default: state <= BOOT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a behavioural instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        pc_choose_memory;
    logic [31:0] mem_pc;
    logic        clear_instruction;
    logic [15:0] instruction;
    logic [31:0] pc_out;
    logic [15:0] immediate;
    logic        fetch_valid;

    int applied = 0;
    int miscompares = 0;

    logic [15:0] mem [0:511];

    always #5 clk = ~clk;

    // Addresses beyond the array return a scrambled address so the wrap case has a known word.
    always_comb begin
        if (imem_addr < 32'd512) imem_data = mem[imem_addr[8:0]];
        else                     imem_data = imem_addr[15:0] ^ 16'h5A5A;
    end

    fetch_stage #(.NOP_WORD(16'h4000), .RESET_VEC_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .jump_taken(jump_taken), .jump_target(jump_target),
        .pc_choose_memory(pc_choose_memory), .mem_pc(mem_pc),
        .clear_instruction(clear_instruction), .instruction(instruction),
        .pc_out(pc_out), .immediate(immediate), .fetch_valid(fetch_valid)
    );

    typedef struct {
        logic        st;
        logic        jt;
        logic [31:0] jtgt;
        logic        pcm;
        logic [31:0] mpc;
        logic        clr;
        logic [15:0] e_instr;
        logic [31:0] e_pc_out;
        logic [15:0] e_imm;
        logic        e_fv;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic jt, logic [31:0] jtgt, logic pcm,
                                logic [31:0] mpc, logic clr, logic [15:0] ei,
                                logic [31:0] epo, logic [15:0] eimm, logic efv,
                                logic [31:0] ea);
        vec_t v;
        v.st = st; v.jt = jt; v.jtgt = jtgt; v.pcm = pcm; v.mpc = mpc; v.clr = clr;
        v.e_instr = ei; v.e_pc_out = epo; v.e_imm = eimm; v.e_fv = efv; v.e_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] ei, input logic [31:0] epo,
                             input logic [15:0] eimm, input logic efv, input logic [31:0] ea);
        check({tag, ".instruction"}, {16'd0, instruction}, {16'd0, ei});
        check({tag, ".pc_out"}, pc_out, epo);
        check({tag, ".immediate"}, {16'd0, immediate}, {16'd0, eimm});
        check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
        check({tag, ".imem_addr"}, imem_addr, ea);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall = 0; jump_taken = 0; jump_target = 0;
        pc_choose_memory = 0; mem_pc = 0; clear_instruction = 0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]    = 16'h0000;
        mem[1]    = 16'h0020;
        mem[9'h30] = 16'hBEEF;

        // st jt jtgt pcm mpc clr | instr pc_out imm fv addr
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1020, 32'h21, 16'h0000, 1, 32'h21));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1021, 32'h22, 16'h0000, 1, 32'h22));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1022, 32'h23, 16'h0000, 1, 32'h23));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1023, 32'h24, 16'h0000, 1, 32'h24));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1024, 32'h25, 16'h0000, 1, 32'h25));
        vecs.push_back(mk(0,1,32'h100,0,0,0, 16'h4000, 32'h25, 16'h0000, 0, 32'h100));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1100, 32'h101, 16'h0000, 1, 32'h101));
        vecs.push_back(mk(0,1,32'h30,0,0,0, 16'h4000, 32'h101, 16'h0000, 0, 32'h30));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h4000, 32'h101, 16'hBEEF, 0, 32'h31));
        vecs.push_back(mk(0,1,32'h40,0,0,1, 16'h4000, 32'h101, 16'hBEEF, 0, 32'h40));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1040, 32'h41, 16'hBEEF, 1, 32'h41));
        vecs.push_back(mk(1,0,0,0,0,0, 16'h1040, 32'h41, 16'hBEEF, 1, 32'h41));
        vecs.push_back(mk(1,0,0,0,0,0, 16'h1040, 32'h41, 16'hBEEF, 1, 32'h41));
        vecs.push_back(mk(1,0,0,0,0,0, 16'h1040, 32'h41, 16'hBEEF, 1, 32'h41));
        vecs.push_back(mk(1,0,0,0,0,1, 16'h1040, 32'h41, 16'hBEEF, 1, 32'h41));
        vecs.push_back(mk(1,0,0,1,32'h55,0, 16'h4000, 32'h41, 16'hBEEF, 0, 32'h55));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h1055, 32'h56, 16'hBEEF, 1, 32'h56));
        vecs.push_back(mk(0,1,32'h70,1,32'h60,0, 16'h4000, 32'h56, 16'hBEEF, 0, 32'h60));
        vecs.push_back(mk(0,1,32'hFFFF_FFFF,0,0,0, 16'h4000, 32'h56, 16'hBEEF, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(0,0,0,0,0,0, 16'hA5A5, 32'h0, 16'hBEEF, 1, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h0000, 32'h1, 16'hBEEF, 1, 32'h1));

        // Reset state
        idle_inputs();
        reset = 1;
        step(); step();
        check_all("reset", 16'h4000, 32'h0, 16'h0, 0, 32'h0);

        // Boot ignores redirects, stall and LDM flag
        reset = 0;
        jump_taken = 1; jump_target = 32'h999; stall = 1; clear_instruction = 1;
        step();
        check_all("boot_hi", 16'h4000, 32'h0, 16'h0, 0, 32'h1);
        pc_choose_memory = 1; mem_pc = 32'h777;
        step();
        check_all("boot_lo", 16'h4000, 32'h0, 16'h0, 0, 32'h20);
        idle_inputs();

        foreach (vecs[i]) begin
            stall = vecs[i].st; jump_taken = vecs[i].jt; jump_target = vecs[i].jtgt;
            pc_choose_memory = vecs[i].pcm; mem_pc = vecs[i].mpc;
            clear_instruction = vecs[i].clr;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc_out,
                      vecs[i].e_imm, vecs[i].e_fv, vecs[i].e_addr);
        end

        // Reset mid-stall during RUN
        idle_inputs();
        stall = 1; reset = 1;
        step();
        check_all("rst_run", 16'h4000, 32'h0, 16'h0, 0, 32'h0);
        reset = 0;
        step();
        check_all("reboot_hi", 16'h4000, 32'h0, 16'h0, 0, 32'h1);

        // Reset mid-boot restarts from the high word
        reset = 1;
        step();
        check_all("rst_boot", 16'h4000, 32'h0, 16'h0, 0, 32'h0);
        reset = 0;
        step();
        check_all("reboot2_hi", 16'h4000, 32'h0, 16'h0, 0, 32'h1);
        step();
        check_all("reboot2_lo", 16'h4000, 32'h0, 16'h0, 0, 32'h20);
        stall = 0;
        step();
        check_all("refetch", 16'h1020, 32'h21, 16'h0, 1, 32'h21);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
